// File: rtl/nvram_pkg.sv
// Shared definitions for the NVRAM upload (save) and download paths.
//   state_t          : upload responder FSM states, also exported for debug
//   NVRAM_OOR_DATA   : byte returned for reads beyond the NVRAM size
//   NVRAM_RESET_DATA : ioctl_din value out of reset
package nvram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PAUSE_REQ,
    PAUSE_PAD,
    READY,
    READ_WAIT,
    DONE
  } state_t;

  localparam logic [7:0] NVRAM_OOR_DATA   = 8'hFF;
  localparam logic [7:0] NVRAM_RESET_DATA = 8'h00;

endpackage

// File: rtl/nvram_upload_responder_if.sv
// HPS ioctl upload bus as seen by the NVRAM upload responder.
//   master : HPS side (hps_io), drives upload/index/rd/addr
//   slave  : responder side, drives din/wait/upload_req
//
// Handshake: ioctl_rd is a one-cycle strobe qualified by ioctl_upload.
// While ioctl_wait is high the HPS must not issue another ioctl_rd.
// ioctl_din holds the requested byte from the cycle ioctl_wait falls
// until the next read completes.
interface nvram_upload_responder_if;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ioctl_upload_req;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_wait, ioctl_upload_req
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_wait, ioctl_upload_req
  );
endinterface

// File: rtl/nvram_dirty_tracker.sv
// Tracks CPU writes into NVRAM and raises the autosave upload request.
//   clk_sys, reset : clock, async active-high reset
//   cpu_nvram_wr   : CPU write strobe into NVRAM (sets dirty)
//   clear          : upload finished (clears dirty; a coincident write wins)
//   idle           : responder is idle, request allowed
//   OSD_STATUS     : OSD open level, edge-detected here
//   autosave       : autosave enable
//   upload_req     : one-cycle request pulse to hps_io
module nvram_dirty_tracker (
  input  logic clk_sys,
  input  logic reset,
  input  logic cpu_nvram_wr,
  input  logic clear,
  input  logic idle,
  input  logic OSD_STATUS,
  input  logic autosave,
  output logic upload_req
);

  logic dirty;
  logic osd_prev;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dirty      <= 1'b0;
      osd_prev   <= 1'b0;
      upload_req <= 1'b0;
    end else begin
      osd_prev <= OSD_STATUS;
      if (cpu_nvram_wr) begin
        dirty <= 1'b1;
      end else if (clear) begin
        dirty <= 1'b0;
      end
      // Only a rising edge of the OSD level fires, so the request cannot
      // repeat while the OSD stays open.
      upload_req <= OSD_STATUS && !osd_prev && autosave && dirty && idle;
    end
  end

endmodule

// File: rtl/nvram_upload_responder.sv
// Serves HPS upload requests for the NVRAM dump on ioctl index DUMPINDEX.
// Pauses the CPU, reads the NVRAM B-port one byte per ioctl_rd and
// returns it on ioctl_din with ioctl_wait flow control.
//   clk_sys, reset  : clock, async active-high reset
//   ioctl           : HPS ioctl upload bus (slave side)
//   OSD_STATUS      : OSD open level (autosave trigger)
//   autosave        : autosave enable
//   cpu_nvram_wr    : CPU write strobe into NVRAM
//   paused          : CPU-paused acknowledge
//   pause_cpu       : pause request
//   nvram_address   : NVRAM B-port read address
//   nvram_data_in   : NVRAM B-port read data (RDLAT cycles after address)
//   busy            : high whenever the FSM is not IDLE
//   state           : FSM state, exported for debug
module nvram_upload_responder
  import nvram_pkg::*;
#(
  parameter int DUMPWIDTH = 8,
  parameter int DUMPINDEX = 4,
  parameter int PAUSEPAD  = 2,
  parameter int RDLAT     = 1
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  nvram_upload_responder_if.slave ioctl,
  input  logic                 OSD_STATUS,
  input  logic                 autosave,
  input  logic                 cpu_nvram_wr,
  input  logic                 paused,
  output logic                 pause_cpu,
  output logic [DUMPWIDTH-1:0] nvram_address,
  input  logic [7:0]           nvram_data_in,
  output logic                 busy,
  output state_t               state
);

  localparam int PW = (PAUSEPAD < 1) ? 1 : $clog2(PAUSEPAD + 1);

  logic                 sel;
  logic [DUMPWIDTH-1:0] rd_addr;
  logic                 rd_oor;
  logic                 pending;
  logic [DUMPWIDTH-1:0] pend_addr;
  logic                 pend_oor;
  logic                 cur_oor;
  logic [PW-1:0]        padcnt;
  logic [1:0]           latcnt;

  assign sel     = ioctl.ioctl_upload && (ioctl.ioctl_index == 8'(DUMPINDEX));
  assign rd_addr = ioctl.ioctl_addr[DUMPWIDTH-1:0];
  assign rd_oor  = |ioctl.ioctl_addr[24:DUMPWIDTH];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      pause_cpu        <= 1'b0;
      ioctl.ioctl_wait <= 1'b0;
      ioctl.ioctl_din  <= NVRAM_RESET_DATA;
      nvram_address    <= '0;
      pending          <= 1'b0;
      pend_addr        <= '0;
      pend_oor         <= 1'b0;
      cur_oor          <= 1'b0;
      padcnt           <= '0;
      latcnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel) begin
            state            <= PAUSE_REQ;
            pause_cpu        <= 1'b1;
            ioctl.ioctl_wait <= 1'b1;
          end
        end

        PAUSE_REQ, PAUSE_PAD: begin
          if (!sel) begin
            state            <= DONE;
            pause_cpu        <= 1'b0;
            ioctl.ioctl_wait <= 1'b0;
            pending          <= 1'b0;
          end else begin
            // A strobe that arrives before the pause settles is parked and
            // served as soon as READY is reached; a second one is dropped.
            if (ioctl.ioctl_rd && !pending) begin
              pending   <= 1'b1;
              pend_addr <= rd_addr;
              pend_oor  <= rd_oor;
            end
            if (state == PAUSE_REQ) begin
              if (paused) begin
                padcnt <= PW'(PAUSEPAD);
                if (PAUSEPAD == 0) begin
                  state            <= READY;
                  ioctl.ioctl_wait <= pending || ioctl.ioctl_rd;
                end else begin
                  state <= PAUSE_PAD;
                end
              end
            end else begin
              padcnt <= padcnt - 1'b1;
              if (padcnt <= PW'(1)) begin
                state            <= READY;
                ioctl.ioctl_wait <= pending || ioctl.ioctl_rd;
              end
            end
          end
        end

        READY: begin
          if (!sel) begin
            state            <= DONE;
            pause_cpu        <= 1'b0;
            ioctl.ioctl_wait <= 1'b0;
            pending          <= 1'b0;
          end else if (pending || ioctl.ioctl_rd) begin
            nvram_address    <= pending ? pend_addr : rd_addr;
            cur_oor          <= pending ? pend_oor : rd_oor;
            pending          <= 1'b0;
            ioctl.ioctl_wait <= 1'b1;
            latcnt           <= 2'(RDLAT);
            state            <= READ_WAIT;
          end else begin
            ioctl.ioctl_wait <= 1'b0;
          end
        end

        READ_WAIT: begin
          // Strobes here are ignored; the HPS is being held off by wait.
          if (!sel) begin
            state            <= DONE;
            pause_cpu        <= 1'b0;
            ioctl.ioctl_wait <= 1'b0;
            pending          <= 1'b0;
          end else if (latcnt == 2'd0) begin
            ioctl.ioctl_din  <= cur_oor ? NVRAM_OOR_DATA : nvram_data_in;
            ioctl.ioctl_wait <= 1'b0;
            state            <= READY;
          end else begin
            latcnt <= latcnt - 2'd1;
          end
        end

        DONE: begin
          pause_cpu        <= 1'b0;
          ioctl.ioctl_wait <= 1'b0;
          pending          <= 1'b0;
          state            <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  nvram_dirty_tracker u_dirty (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .cpu_nvram_wr (cpu_nvram_wr),
    .clear        (state == DONE),
    .idle         (state == IDLE),
    .OSD_STATUS   (OSD_STATUS),
    .autosave     (autosave),
    .upload_req   (ioctl.ioctl_upload_req)
  );

endmodule
